// File: rtl/reg_file_param.sv
// Parametrised 2-write/2-read register file with async clear-to-zero reset,
// optional hardwired r0, optional write-to-read bypass and a sequenced clear sweep.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] regDst1,
  input  logic [DATA_W-1:0] bus_w,
  input  logic              regWrite2,
  input  logic [ADDR_W-1:0] regDst2,
  input  logic [DATA_W-1:0] bus2_w,
  input  logic [ADDR_W-1:0] regSrc1,
  input  logic [ADDR_W-1:0] regSrc2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we1, we2;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Terminate on the last index so the pointer never wraps into a second pass.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign we1 = (state_q == ST_IDLE) && regWrite  && !(ZERO_REG && (regDst1 == '0));
  assign we2 = (state_q == ST_IDLE) && regWrite2 && !(ZERO_REG && (regDst2 == '0));

  // Port 2 is written last so it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (we1) mem_q[regDst1] <= bus_w;
      if (we2) mem_q[regDst2] <= bus2_w;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = mem_q[addr];
    if (ZERO_REG && (addr == '0)) begin
      val = '0;
    end else if (BYPASS && (state_q == ST_IDLE) && regWrite2 && (regDst2 == addr)) begin
      val = bus2_w;
    end else if (BYPASS && (state_q == ST_IDLE) && regWrite && (regDst1 == addr)) begin
      val = bus_w;
    end
    return val;
  endfunction

  always_comb begin
    out1 = read_port(regSrc1);
    out2 = read_port(regSrc2);
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a default instance and a ZERO_REG+BYPASS instance share
// stimulus and are compared against a behavioural array model.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        regWrite, regWrite2, clr_req;
  logic [3:0]  regDst1, regDst2, regSrc1, regSrc2;
  logic [31:0] bus_w, bus2_w;
  logic [31:0] out1_a, out2_a, out1_b, out2_b;
  logic        busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .regWrite(regWrite), .regDst1(regDst1), .bus_w(bus_w),
    .regWrite2(regWrite2), .regDst2(regDst2), .bus2_w(bus2_w),
    .regSrc1(regSrc1), .regSrc2(regSrc2), .out1(out1_a), .out2(out2_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .regWrite(regWrite), .regDst1(regDst1), .bus_w(bus_w),
    .regWrite2(regWrite2), .regDst2(regDst2), .bus2_w(bus2_w),
    .regSrc1(regSrc1), .regSrc2(regSrc2), .out1(out1_b), .out2(out2_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  // Reference model: array contents plus "sweep in progress, next index k".
  logic [31:0] m_a [16];
  logic [31:0] m_b [16];
  bit          m_sweep;
  int          m_k;
  bit          m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_a[i] = 0;
        m_b[i] = 0;
      end
      m_sweep = 0;
      m_k = 0;
      m_done = 0;
    end else if (m_sweep) begin
      m_a[m_k] = 0;
      m_b[m_k] = 0;
      m_done = (m_k == 15);
      if (m_k == 15) m_sweep = 0;
      else m_k = m_k + 1;
    end else begin
      m_done = 0;
      if (regWrite) begin
        m_a[regDst1] = bus_w;
        if (regDst1 != 0) m_b[regDst1] = bus_w;
      end
      if (regWrite2) begin
        m_a[regDst2] = bus2_w;
        if (regDst2 != 0) m_b[regDst2] = bus2_w;
      end
      if (clr_req) begin
        m_sweep = 1;
        m_k = 0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit cfg_b, input logic [3:0] a);
    if (!cfg_b) return m_a[a];
    if (a == 0) return 32'h0;
    if (!m_sweep && regWrite2 && regDst2 == a) return bus2_w;
    if (!m_sweep && regWrite && regDst1 == a) return bus_w;
    return m_b[a];
  endfunction

  task automatic idle_inputs();
    regWrite = 0; regWrite2 = 0; clr_req = 0;
    regDst1 = 0; regDst2 = 0; bus_w = 0; bus2_w = 0;
    regSrc1 = 0; regSrc2 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 0;
    #5;
    checks += 2;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy_a, busy_b);
    end
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b/%b exp=0/0", done_a, done_b);
    end
    for (int a = 0; a < 16; a++) begin
      regSrc1 = 4'(a); regSrc2 = 4'(15 - a);
      #1;
      checks++;
      if (out1_a !== 0 || out2_a !== 0 || out1_b !== 0 || out2_b !== 0) begin
        failures++;
        $display("FAIL reset_read r%0d got=%h/%h/%h/%h exp=0", a, out1_a, out2_a, out1_b, out2_b);
      end
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_write_basic();
    next_cycle();
    regWrite = 1; regDst1 = 5; bus_w = 32'hDEADBEEF; regSrc1 = 5;
    @(negedge clk);
    checks += 2;
    if (out1_a !== 32'h0) begin
      failures++; $display("FAIL wr_same_cycle_nobyp got=%h exp=%h", out1_a, 32'h0);
    end
    if (out1_b !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_same_cycle_byp got=%h exp=%h", out1_b, 32'hDEADBEEF);
    end
    next_cycle();
    regWrite = 0;
    @(negedge clk);
    checks += 2;
    if (out1_a !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_next_a got=%h exp=%h", out1_a, 32'hDEADBEEF);
    end
    if (out1_b !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_next_b got=%h exp=%h", out1_b, 32'hDEADBEEF);
    end
  endtask

  task automatic test_dual_write();
    next_cycle();
    regWrite = 1; regDst1 = 3; bus_w = 32'h11111111;
    regWrite2 = 1; regDst2 = 3; bus2_w = 32'h22222222;
    regSrc1 = 3;
    @(negedge clk);
    checks++;
    if (out1_b !== 32'h22222222) begin
      failures++; $display("FAIL dual_same_byp got=%h exp=%h", out1_b, 32'h22222222);
    end
    next_cycle();
    regDst1 = 1; bus_w = 32'hA; regDst2 = 2; bus2_w = 32'hB;
    @(negedge clk);
    checks++;
    if (out1_a !== 32'h22222222) begin
      failures++; $display("FAIL dual_same_addr got=%h exp=%h", out1_a, 32'h22222222);
    end
    next_cycle();
    regWrite = 0; regWrite2 = 0; regSrc1 = 1; regSrc2 = 2;
    @(negedge clk);
    checks += 2;
    if (out1_a !== 32'hA || out1_b !== 32'hA) begin
      failures++; $display("FAIL dual_r1 got=%h/%h exp=%h", out1_a, out1_b, 32'hA);
    end
    if (out2_a !== 32'hB || out2_b !== 32'hB) begin
      failures++; $display("FAIL dual_r2 got=%h/%h exp=%h", out2_a, out2_b, 32'hB);
    end
  endtask

  task automatic test_zero_reg();
    next_cycle();
    regWrite = 1; regDst1 = 0; bus_w = 32'hFFFFFFFF; regSrc1 = 0;
    @(negedge clk);
    checks++;
    if (out1_b !== 32'h0) begin
      failures++; $display("FAIL zero_during got=%h exp=%h", out1_b, 32'h0);
    end
    next_cycle();
    regWrite = 0;
    @(negedge clk);
    checks += 2;
    if (out1_b !== 32'h0) begin
      failures++; $display("FAIL zero_after got=%h exp=%h", out1_b, 32'h0);
    end
    if (out1_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL zero_off_r0 got=%h exp=%h", out1_a, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_bypass();
    next_cycle();
    regWrite = 1; regDst1 = 7; bus_w = 32'h1234; regSrc1 = 7;
    @(negedge clk);
    checks += 2;
    if (out1_b !== 32'h1234) begin
      failures++; $display("FAIL byp_on got=%h exp=%h", out1_b, 32'h1234);
    end
    if (out1_a !== 32'h0) begin
      failures++; $display("FAIL byp_off_old got=%h exp=%h", out1_a, 32'h0);
    end
    next_cycle();
    regWrite = 0;
    @(negedge clk);
    checks++;
    if (out1_a !== 32'h1234) begin
      failures++; $display("FAIL byp_off_next got=%h exp=%h", out1_a, 32'h1234);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      regWrite = 1; regDst1 = 4'(2 * i); bus_w = base + 32'(2 * i);
      regWrite2 = 1; regDst2 = 4'(2 * i + 1); bus2_w = base + 32'(2 * i + 1);
    end
    next_cycle();
    regWrite = 0; regWrite2 = 0;
  endtask

  task automatic test_clear_sweep();
    logic [31:0] ea, eb;
    fill(32'h100);
    clr_req = 1;
    next_cycle();  // edge N
    clr_req = 0;
    regWrite = 1; regDst1 = 9; bus_w = 32'h55;
    for (int c = 0; c <= 17; c++) begin
      if (c == 16) regWrite = 0;
      @(negedge clk);
      checks += 2;
      if (busy_a !== (c < 16) || busy_b !== (c < 16)) begin
        failures++; $display("FAIL sweep_busy c=%0d got=%b/%b exp=%b", c, busy_a, busy_b, c < 16);
      end
      if (done_a !== (c == 16) || done_b !== (c == 16)) begin
        failures++; $display("FAIL sweep_done c=%0d got=%b/%b exp=%b", c, done_a, done_b, c == 16);
      end
      for (int a = 0; a < 16; a++) begin
        regSrc1 = 4'(a); regSrc2 = 4'(15 - a);
        #1;
        ea = (a < c) ? 32'h0 : 32'h100 + 32'(a);
        eb = (a == 0) ? 32'h0 : ea;
        checks++;
        if (out1_a !== ea || out1_b !== eb) begin
          failures++; $display("FAIL sweep_read c=%0d r%0d got=%h/%h exp=%h/%h", c, a, out1_a, out1_b, ea, eb);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill(32'hA0);
    clr_req = 1;
    next_cycle();
    clr_req = 0;
    repeat (6) next_cycle();
    #4 rst_n = 0;
    #2;
    checks++;
    if (busy_a !== 0 || busy_b !== 0 || done_a !== 0 || done_b !== 0) begin
      failures++; $display("FAIL midrst_flags got=%b%b%b%b exp=0000", busy_a, busy_b, done_a, done_b);
    end
    for (int a = 0; a < 16; a++) begin
      regSrc1 = 4'(a); regSrc2 = 4'(a);
      #1;
      checks++;
      if (out1_a !== 0 || out2_b !== 0) begin
        failures++; $display("FAIL midrst_read r%0d got=%h/%h exp=0", a, out1_a, out2_b);
      end
    end
    @(negedge clk) rst_n = 1;
    for (int c = 0; c < 18; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (done_a !== 0 || done_b !== 0 || busy_a !== 0) begin
        failures++; $display("FAIL midrst_idle c=%0d got=%b%b%b exp=000", c, done_a, done_b, busy_a);
      end
    end
    next_cycle();
    clr_req = 1;
    next_cycle();
    clr_req = 0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      checks++;
      if (busy_b !== (c < 16) || done_a !== (c == 16)) begin
        failures++; $display("FAIL resweep c=%0d got=%b%b exp=%b%b", c, busy_b, done_a, c < 16, c == 16);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      regWrite = 1'($urandom_range(0, 1));
      regWrite2 = 1'($urandom_range(0, 1));
      regDst1 = 4'($urandom_range(0, 15));
      regDst2 = ($urandom_range(0, 3) == 0) ? regDst1 : 4'($urandom_range(0, 15));
      bus_w = $urandom; bus2_w = $urandom;
      regSrc1 = ($urandom_range(0, 1) == 0) ? regDst1 : 4'($urandom_range(0, 15));
      regSrc2 = ($urandom_range(0, 1) == 0) ? regDst2 : 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      checks += 3;
      if (out1_a !== exp_rd(0, regSrc1) || out2_a !== exp_rd(0, regSrc2)) begin
        failures++;
        $display("FAIL rand_a n=%0d got=%h/%h exp=%h/%h", n, out1_a, out2_a, exp_rd(0, regSrc1), exp_rd(0, regSrc2));
      end
      if (out1_b !== exp_rd(1, regSrc1) || out2_b !== exp_rd(1, regSrc2)) begin
        failures++;
        $display("FAIL rand_b n=%0d got=%h/%h exp=%h/%h", n, out1_b, out2_b, exp_rd(1, regSrc1), exp_rd(1, regSrc2));
      end
      if (busy_a !== m_sweep || busy_b !== m_sweep || done_a !== m_done || done_b !== m_done) begin
        failures++;
        $display("FAIL rand_ctl n=%0d got=%b%b%b%b exp=%b%b", n, busy_a, busy_b, done_a, done_b, m_sweep, m_done);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_basic();
    test_dual_write();
    test_zero_reg();
    test_bypass();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
